// File: rtl/ladybird_bus_arbiter.sv
// Round-robin arbiter sharing one peripheral target among N_REQ primaries, with an
// in-order ID FIFO that steers load return data back to the primary that issued it.
module ladybird_bus_arbiter #(
  parameter int N_REQ     = 2,
  parameter int MAX_OUTST = 4
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [N_REQ-1:0]             m_req,
  input  logic [N_REQ*32-1:0]          m_addr,
  input  logic [N_REQ*32-1:0]          m_wdata,
  input  logic [N_REQ*4-1:0]           m_wstrb,
  output logic [N_REQ-1:0]             m_gnt,
  output logic [N_REQ-1:0]             m_rdgnt,
  output logic [31:0]                  m_rdata,
  output logic                         s_req,
  output logic [31:0]                  s_addr,
  output logic [31:0]                  s_wdata,
  output logic [3:0]                   s_wstrb,
  input  logic                         s_gnt,
  input  logic                         s_rdgnt,
  input  logic [31:0]                  s_rdata,
  output logic [$clog2(MAX_OUTST):0]   outst_cnt,
  output logic                         err_unexp
);

  localparam int IDW = $clog2(N_REQ);
  localparam int PW  = $clog2(MAX_OUTST);

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   sel;
  logic [IDW-1:0]   lock_id;
  logic [IDW-1:0]   head_id;
  logic             locked;
  logic             found;
  logic [IDW-1:0]   fifo_mem [MAX_OUTST];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [N_REQ-1:0] eligible;
  logic             accept;
  logic             push;
  logic             pop;

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IDW'(s);
  endfunction

  assign fifo_full  = (count == (PW+1)'(MAX_OUTST));
  assign fifo_empty = (count == '0);

  always_comb begin
    eligible = '0;
    for (int k = 0; k < N_REQ; k++) begin
      eligible[k] = m_req[k] & ((m_wstrb[4*k +: 4] != 4'b0) | ~fifo_full);
    end
  end

  // A request left waiting on s_gnt keeps its slot even if a pop makes an
  // earlier-priority load eligible in the meantime.
  always_comb begin
    sel   = rr_ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && eligible[wrap_idx(rr_ptr, i)]) begin
        sel   = wrap_idx(rr_ptr, i);
        found = 1'b1;
      end
    end
    if (locked && eligible[lock_id]) sel = lock_id;
  end

  assign s_req  = |eligible;
  assign accept = s_req & s_gnt;
  assign push   = accept & (s_wstrb == 4'b0);
  assign pop    = s_rdgnt & ~fifo_empty;

  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    if (s_req) begin
      s_addr  = m_addr[int'(sel)*32 +: 32];
      s_wdata = m_wdata[int'(sel)*32 +: 32];
      s_wstrb = m_wstrb[int'(sel)*4 +: 4];
    end
  end

  assign head_id = fifo_mem[rd_ptr];

  always_comb begin
    m_gnt   = '0;
    m_rdgnt = '0;
    if (accept) m_gnt[sel] = 1'b1;
    if (pop) m_rdgnt[head_id] = 1'b1;
  end

  assign m_rdata   = s_rdata;
  assign outst_cnt = count;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rr_ptr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_unexp <= 1'b0;
      locked    <= 1'b0;
      lock_id   <= '0;
      for (int i = 0; i < MAX_OUTST; i++) fifo_mem[i] <= '0;
    end else begin
      if (accept) rr_ptr <= (int'(sel) == N_REQ-1) ? '0 : sel + 1'b1;
      locked  <= s_req & ~s_gnt;
      lock_id <= sel;
      if (push) begin
        fifo_mem[wr_ptr] <= sel;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (s_rdgnt && fifo_empty) err_unexp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
// Scoreboard bench for ladybird_bus_arbiter: directed vectors queue expected grants and
// read returns, and a negedge monitor pops and compares them as the DUT presents them.
module tb_ladybird_bus_arbiter;

  localparam logic [31:0] A0 = 32'hA000_0000;
  localparam logic [31:0] A1 = 32'hB000_0004;
  localparam logic [31:0] W0 = 32'h1111_0000;
  localparam logic [31:0] W1 = 32'h2222_0001;

  typedef struct {
    int          cyc;
    logic [1:0]  gnt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } gnt_item_t;

  typedef struct {
    int          cyc;
    logic [1:0]  rdgnt;
    logic [31:0] data;
  } rd_item_t;

  logic        clk;
  logic        nrst;
  logic [1:0]  m_req;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_gnt;
  logic [1:0]  m_rdgnt;
  logic [31:0] m_rdata;
  logic        s_req;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_gnt;
  logic        s_rdgnt;
  logic [31:0] s_rdata;
  logic [2:0]  outst_cnt;
  logic        err_unexp;

  gnt_item_t gnt_q[$];
  rd_item_t  rd_q[$];
  int        cyc = 0;
  int        n_checks = 0;
  int        n_fails = 0;

  ladybird_bus_arbiter #(.N_REQ(2), .MAX_OUTST(4)) dut (
    .clk(clk), .nrst(nrst),
    .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_gnt(m_gnt), .m_rdgnt(m_rdgnt), .m_rdata(m_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_gnt(s_gnt), .s_rdgnt(s_rdgnt), .s_rdata(s_rdata),
    .outst_cnt(outst_cnt), .err_unexp(err_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one bus cycle just after the rising edge, queues what the DUT should
  // present in that cycle, and returns at the following falling edge.
  task automatic apply_stimulus(input logic [1:0] req, input logic [3:0] ws0, input logic [3:0] ws1,
                                input logic sg, input logic srg, input logic [31:0] rdat,
                                input logic [1:0] exp_gnt, input logic [1:0] exp_rd);
    gnt_item_t g;
    rd_item_t  r;
    @(posedge clk);
    #1;
    m_req   = req;
    m_wstrb = {ws1, ws0};
    s_gnt   = sg;
    s_rdgnt = srg;
    s_rdata = rdat;
    if (exp_gnt != 2'b00) begin
      g.cyc   = cyc;
      g.gnt   = exp_gnt;
      g.addr  = exp_gnt[0] ? A0 : A1;
      g.wdata = exp_gnt[0] ? W0 : W1;
      g.wstrb = exp_gnt[0] ? ws0 : ws1;
      gnt_q.push_back(g);
    end
    if (exp_rd != 2'b00) begin
      r.cyc   = cyc;
      r.rdgnt = exp_rd;
      r.data  = rdat;
      rd_q.push_back(r);
    end
    @(negedge clk);
  endtask

  // Monitor: every presented grant or read return must match the head of its queue.
  always @(negedge clk) begin
    if (m_gnt != 2'b00) begin
      if (gnt_q.size() == 0) begin
        check_output("unexpected_gnt", {30'b0, m_gnt}, 32'h0);
      end else begin
        gnt_item_t g;
        g = gnt_q.pop_front();
        check_output("gnt_cycle", cyc, g.cyc);
        check_output("m_gnt", {30'b0, m_gnt}, {30'b0, g.gnt});
        check_output("s_addr", s_addr, g.addr);
        check_output("s_wdata", s_wdata, g.wdata);
        check_output("s_wstrb", {28'b0, s_wstrb}, {28'b0, g.wstrb});
      end
    end
    if (m_rdgnt != 2'b00) begin
      if (rd_q.size() == 0) begin
        check_output("unexpected_rdgnt", {30'b0, m_rdgnt}, 32'h0);
      end else begin
        rd_item_t r;
        r = rd_q.pop_front();
        check_output("rdgnt_cycle", cyc, r.cyc);
        check_output("m_rdgnt", {30'b0, m_rdgnt}, {30'b0, r.rdgnt});
        check_output("m_rdata", m_rdata, r.data);
      end
    end
  end

  initial begin
    nrst    = 1'b0;
    m_req   = 2'b00;
    m_addr  = {A1, A0};
    m_wdata = {W1, W0};
    m_wstrb = 8'h00;
    s_gnt   = 1'b0;
    s_rdgnt = 1'b0;
    s_rdata = 32'h0;

    // Reset state; s_req and the address mux follow m_req even while reset is held
    repeat (2) @(negedge clk);
    check_output("rst_m_gnt", {30'b0, m_gnt}, 32'h0);
    check_output("rst_m_rdgnt", {30'b0, m_rdgnt}, 32'h0);
    check_output("rst_outst_cnt", {29'b0, outst_cnt}, 32'h0);
    check_output("rst_err_unexp", {31'b0, err_unexp}, 32'h0);
    check_output("rst_s_req_idle", {31'b0, s_req}, 32'h0);
    m_req = 2'b10;
    #1;
    check_output("rst_s_req_follow", {31'b0, s_req}, 32'h1);
    check_output("rst_s_addr_follow", s_addr, A1);
    m_req = 2'b00;
    @(posedge clk);
    #1;
    nrst = 1'b1;

    // Two continuous loaders alternate, with returns routed in issue order
    apply_stimulus(2'b11, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0,         2'b01, 2'b00);
    apply_stimulus(2'b11, 4'h0, 4'h0, 1'b1, 1'b1, 32'hDEAD_0001, 2'b10, 2'b01);
    apply_stimulus(2'b11, 4'h0, 4'h0, 1'b1, 1'b1, 32'hDEAD_0002, 2'b01, 2'b10);
    apply_stimulus(2'b11, 4'h0, 4'h0, 1'b1, 1'b1, 32'hDEAD_0003, 2'b10, 2'b01);
    apply_stimulus(2'b00, 4'h0, 4'h0, 1'b0, 1'b1, 32'hDEAD_0004, 2'b00, 2'b10);

    // Only primary 1 requests (stores): granted every cycle as the pointer wraps to 0
    apply_stimulus(2'b10, 4'h0, 4'hF, 1'b1, 1'b0, 32'h0, 2'b10, 2'b00);
    check_output("outst_after_drain", {29'b0, outst_cnt}, 32'h0);
    apply_stimulus(2'b10, 4'h0, 4'hF, 1'b1, 1'b0, 32'h0, 2'b10, 2'b00);
    apply_stimulus(2'b10, 4'h0, 4'hF, 1'b1, 1'b0, 32'h0, 2'b10, 2'b00);

    // Fill the FIFO with IDs 0,1,0,1
    apply_stimulus(2'b11, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0, 2'b01, 2'b00);
    apply_stimulus(2'b11, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0, 2'b10, 2'b00);
    apply_stimulus(2'b11, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0, 2'b01, 2'b00);
    apply_stimulus(2'b11, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0, 2'b10, 2'b00);
    // Full: load from 0 blocked, store from 1 still granted
    apply_stimulus(2'b11, 4'h0, 4'hF, 1'b1, 1'b0, 32'h0, 2'b10, 2'b00);
    check_output("outst_full", {29'b0, outst_cnt}, 32'h4);
    check_output("s_req_store_when_full", {31'b0, s_req}, 32'h1);
    apply_stimulus(2'b01, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0, 2'b00, 2'b00);
    check_output("s_req_load_when_full", {31'b0, s_req}, 32'h0);

    // Full with a pop in the same cycle: load waits one cycle, count 4 -> 3 -> 4
    apply_stimulus(2'b01, 4'h0, 4'h0, 1'b1, 1'b1, 32'hBEEF_0001, 2'b00, 2'b01);
    check_output("outst_pop_cycle", {29'b0, outst_cnt}, 32'h4);
    apply_stimulus(2'b01, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0, 2'b01, 2'b00);
    check_output("outst_after_pop", {29'b0, outst_cnt}, 32'h3);
    apply_stimulus(2'b00, 4'h0, 4'h0, 1'b0, 1'b1, 32'hBEEF_0002, 2'b00, 2'b10);
    check_output("outst_refilled", {29'b0, outst_cnt}, 32'h4);
    apply_stimulus(2'b00, 4'h0, 4'h0, 1'b0, 1'b1, 32'hBEEF_0003, 2'b00, 2'b01);
    apply_stimulus(2'b00, 4'h0, 4'h0, 1'b0, 1'b1, 32'hBEEF_0004, 2'b00, 2'b10);
    apply_stimulus(2'b00, 4'h0, 4'h0, 1'b0, 1'b1, 32'hBEEF_0005, 2'b00, 2'b01);
    apply_stimulus(2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00);
    check_output("outst_empty", {29'b0, outst_cnt}, 32'h0);
    check_output("err_clear_before", {31'b0, err_unexp}, 32'h0);

    // Unexpected return while empty: no m_rdgnt, sticky error
    apply_stimulus(2'b00, 4'h0, 4'h0, 1'b0, 1'b1, 32'hCAFE_0001, 2'b00, 2'b00);
    check_output("err_not_yet", {31'b0, err_unexp}, 32'h0);
    apply_stimulus(2'b10, 4'h0, 4'hF, 1'b1, 1'b0, 32'h0, 2'b10, 2'b00);
    check_output("err_set", {31'b0, err_unexp}, 32'h1);
    apply_stimulus(2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00);
    check_output("err_sticky", {31'b0, err_unexp}, 32'h1);

    // Two loads outstanding with rr_ptr at 1, then asynchronous reset
    apply_stimulus(2'b11, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0, 2'b01, 2'b00);
    apply_stimulus(2'b01, 4'h0, 4'h0, 1'b1, 1'b0, 32'h0, 2'b01, 2'b00);
    apply_stimulus(2'b11, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00);
    check_output("outst_two", {29'b0, outst_cnt}, 32'h2);
    check_output("s_addr_rr1", s_addr, A1);
    #2;
    nrst = 1'b0;
    #1;
    check_output("async_outst", {29'b0, outst_cnt}, 32'h0);
    check_output("async_err", {31'b0, err_unexp}, 32'h0);
    check_output("async_s_addr_rr0", s_addr, A0);
    check_output("async_s_req", {31'b0, s_req}, 32'h1);
    m_req = 2'b00;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    apply_stimulus(2'b00, 4'h0, 4'h0, 1'b0, 1'b1, 32'hCAFE_0002, 2'b00, 2'b00);
    check_output("late_err_not_yet", {31'b0, err_unexp}, 32'h0);
    apply_stimulus(2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00);
    check_output("late_err_set", {31'b0, err_unexp}, 32'h1);
    check_output("late_outst", {29'b0, outst_cnt}, 32'h0);

    repeat (2) @(negedge clk);
    check_output("gnt_q_leftover", gnt_q.size(), 32'h0);
    check_output("rd_q_leftover", rd_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
